// File: rtl/fp_issue_sequencer_pkg.sv
// fp_seq_pkg -- shared definitions for the FP issue sequencer.
//   fp_seq_state_e : sequencer FSM states (IDLE, EXEC, MEM_HI)
//   CNT_W          : width of the latency counter
//   FP_SINGLE_LAT  : cycles of Stall for a single-precision arith op
//   FP_DOUBLE_LAT  : cycles of Stall for a double-precision arith op
package fp_seq_pkg;

  localparam int CNT_W = 3;

  localparam logic [CNT_W-1:0] FP_SINGLE_LAT = 3'd2;
  localparam logic [CNT_W-1:0] FP_DOUBLE_LAT = 3'd4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    MEM_HI = 2'd2
  } fp_seq_state_e;

endpackage

// File: rtl/fp_issue_sequencer_if.sv
// fp_issue_sequencer_if -- decode-side bundle between the pipeline and the
// FP issue sequencer.
//   Pipeline -> sequencer : issue_valid, floatop, double, FPLoadStore,
//                           MemRead, MemWrite, flush
//   Sequencer -> pipeline : Stall, fpu_start, fpu_double, fpu_result_valid,
//                           mem_hi, fp_double_unsup
// Handshake: an instruction is taken in any cycle where issue_valid=1, the
// sequencer is idle and flush=0. There is no ready signal; instead Stall
// freezes fetch/decode and the pipeline keeps the instruction steady while
// Stall is high. Anything presented while the sequencer is busy is ignored.
interface fp_issue_sequencer_if;
  logic issue_valid;
  logic floatop;
  logic double;
  logic FPLoadStore;
  logic MemRead;
  logic MemWrite;
  logic flush;
  logic Stall;
  logic fpu_start;
  logic fpu_double;
  logic fpu_result_valid;
  logic mem_hi;
  logic fp_double_unsup;

  modport master (
    output issue_valid, floatop, double, FPLoadStore, MemRead, MemWrite, flush,
    input  Stall, fpu_start, fpu_double, fpu_result_valid, mem_hi, fp_double_unsup
  );

  modport slave (
    input  issue_valid, floatop, double, FPLoadStore, MemRead, MemWrite, flush,
    output Stall, fpu_start, fpu_double, fpu_result_valid, mem_hi, fp_double_unsup
  );
endinterface

// File: rtl/fp_issue_sequencer_lat_counter.sv
// fp_lat_counter -- FPU latency down-counter.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   load_i         : load load_val_i (highest priority after reset)
//   load_val_i     : value to load
//   clr_i          : force to zero
//   dec_i          : decrement; saturates at zero, never wraps
//   count_next_o   : value the counter takes at the next edge
//   zero_o         : current count is zero
module fp_lat_counter
  import fp_seq_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             clr_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] count_next_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (clr_i) begin
      count_d = '0;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_next_o = count_d;
  assign zero_o       = (count_q == '0);

endmodule

// File: rtl/fp_issue_sequencer.sv
// fp_issue_sequencer -- sequences multi-cycle FP arithmetic and the second
// word of double-precision FP loads/stores, stalling fetch/decode meanwhile.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fp_issue_sequencer_if.slave (decode controls in, Stall and
//              FPU/memory controls out; all outputs registered)
//   state_o  : current FSM state, for debug
// Build option: define FP_SEQ_DOUBLE_EN for double-precision support. Without
// it doubles run at single latency, have no upper-word beat, fpu_double stays
// 0 and fp_double_unsup pulses for every accepted op with double=1.
module fp_issue_sequencer
  import fp_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  fp_issue_sequencer_if.slave  bus,
  output fp_seq_state_e        state_o
);

`ifdef FP_SEQ_DOUBLE_EN
  localparam bit DBL_EN = 1'b1;
`else
  localparam bit DBL_EN = 1'b0;
`endif

  fp_seq_state_e    state_q, state_d;
  logic             accept, is_arith, is_dmem, load;
  logic [CNT_W-1:0] lat_m1, cnt_next;
  logic             cnt_zero;
  logic             stall_q, start_q, fdbl_q, rv_q, mem_hi_q, unsup_q;

  always_comb begin
    accept   = bus.issue_valid & (state_q == IDLE) & ~bus.flush;
    is_arith = bus.floatop & ~bus.FPLoadStore;
    is_dmem  = bus.FPLoadStore & bus.double & (bus.MemRead | bus.MemWrite) & DBL_EN;
    lat_m1   = (DBL_EN && bus.double) ? (FP_DOUBLE_LAT - 3'd1) : (FP_SINGLE_LAT - 3'd1);
    load     = accept & is_arith;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept && is_arith)     state_d = EXEC;
        else if (accept && is_dmem) state_d = MEM_HI;
      end
      EXEC: begin
        if (bus.flush || cnt_zero) state_d = IDLE;
      end
      MEM_HI:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counter is cleared whenever the FSM is not going to be in EXEC, so it
  // reads zero outside EXEC and a flush leaves nothing behind.
  fp_lat_counter u_cnt (
    .clk_i        (clk),
    .rst_i        (rst),
    .load_i       (load),
    .load_val_i   (lat_m1),
    .clr_i        (state_d != EXEC),
    .dec_i        (state_q == EXEC),
    .count_next_o (cnt_next),
    .zero_o       (cnt_zero)
  );

  // Outputs are computed from next state so they line up with the state
  // they describe in the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      stall_q  <= 1'b0;
      start_q  <= 1'b0;
      fdbl_q   <= 1'b0;
      rv_q     <= 1'b0;
      mem_hi_q <= 1'b0;
      unsup_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      stall_q  <= (state_d != IDLE);
      start_q  <= load;
      rv_q     <= (state_d == EXEC) && (cnt_next == '0);
      mem_hi_q <= (state_d == MEM_HI);
      unsup_q  <= accept & bus.double & ~DBL_EN;
      if (accept) fdbl_q <= bus.double & DBL_EN;
    end
  end

  assign bus.Stall            = stall_q;
  assign bus.fpu_start        = start_q;
  assign bus.fpu_double       = fdbl_q;
  assign bus.fpu_result_valid = rv_q;
  assign bus.mem_hi           = mem_hi_q;
  assign bus.fp_double_unsup  = unsup_q;
  assign state_o              = state_q;

endmodule

// File: tb/tb_fp_issue_sequencer.sv
// Bench for fp_issue_sequencer. Each issued op pushes its expected
// per-cycle output vectors {Stall, fpu_start, fpu_double, fpu_result_valid,
// mem_hi, fp_double_unsup} into exp_q; every following cycle pops one and
// compares it against the DUT.
module tb_fp_issue_sequencer;
  import fp_seq_pkg::*;

  localparam int W = 6;
`ifdef FP_SEQ_DOUBLE_EN
  localparam bit DEN = 1'b1;
`else
  localparam bit DEN = 1'b0;
`endif
  localparam int SLAT = 2;
  localparam int DLAT = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_issue_sequencer_if bus ();
  fp_seq_state_e state;

  fp_issue_sequencer dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  logic fdbl_cur = 1'b0;
  string cur_tag = "reset";

  task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] vec(input logic s, st, rv, mh, un);
    return {s, st, fdbl_cur, rv, mh, un};
  endfunction

  task automatic step();
    logic [W-1:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) e = vec(0, 0, 0, 0, 0);
    else e = exp_q.pop_front();
    chk(cur_tag, {bus.Stall, bus.fpu_start, bus.fpu_double, bus.fpu_result_valid,
                  bus.mem_hi, bus.fp_double_unsup}, e);
  endtask

  // Expected cycles N+1.. for an op accepted at N, keeping the first 'keep'.
  task automatic push_seq(input logic fo, dbl, fls, mr, mw, input int keep,
                          output int n, output fp_seq_state_e st1);
    logic [W-1:0] s[$];
    bit arith, dmem, un;
    int lat;
    arith = fo & ~fls;
    dmem  = fls & dbl & (mr | mw) & DEN;
    un    = dbl & ~DEN;
    lat   = (DEN && dbl) ? DLAT : SLAT;
    fdbl_cur = DEN ? dbl : 1'b0;
    if (arith) begin
      st1 = EXEC;
      for (int k = 1; k <= lat; k++) s.push_back(vec(1, k == 1, k == lat, 0, un && k == 1));
    end else if (dmem) begin
      st1 = MEM_HI;
      s.push_back(vec(1, 0, 0, 1, 0));
    end else begin
      st1 = IDLE;
      s.push_back(vec(0, 0, 0, 0, un));
    end
    s.push_back(vec(0, 0, 0, 0, 0));
    n = 0;
    for (int i = 0; i < s.size() && i < keep; i++) begin
      exp_q.push_back(s[i]);
      n++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, fo, dbl, fls, mr, mw, fl);
    bus.issue_valid = v;  bus.floatop = fo;  bus.double = dbl;
    bus.FPLoadStore = fls; bus.MemRead = mr; bus.MemWrite = mw; bus.flush = fl;
  endtask

  // hold=1 keeps issue_valid high through the whole busy period.
  task automatic issue(input string tag, input logic fo, dbl, fls, mr, mw, input bit hold);
    int n;
    fp_seq_state_e st1;
    cur_tag = tag;
    drive(1, fo, dbl, fls, mr, mw, 0);
    push_seq(fo, dbl, fls, mr, mw, 99, n, st1);
    for (int k = 1; k <= n; k++) begin
      step();
      if (k == 1) chk({tag, "_state1"}, {4'b0, state}, {4'b0, st1});
      if (!hold || k == n) bus.issue_valid = 1'b0;
    end
    step();
    chk({tag, "_state_end"}, {4'b0, state}, {4'b0, IDLE});
  endtask

  task automatic flush_op(input string tag, input logic fo, dbl, fls, mr, mw, input int k);
    int n;
    fp_seq_state_e st1;
    cur_tag = tag;
    drive(1, fo, dbl, fls, mr, mw, 0);
    push_seq(fo, dbl, fls, mr, mw, k, n, st1);
    for (int i = 1; i <= n; i++) begin
      step();
      bus.issue_valid = 1'b0;
    end
    bus.flush = 1'b1;
    exp_q.push_back(vec(0, 0, 0, 0, 0));
    step();
    chk({tag, "_state"}, {4'b0, state}, {4'b0, IDLE});
    bus.flush = 1'b0;
    step();
  endtask

  task automatic rst_op(input string tag, input logic fo, dbl);
    int n;
    fp_seq_state_e st1;
    cur_tag = tag;
    drive(1, fo, dbl, 0, 0, 0, 0);
    push_seq(fo, dbl, 0, 0, 0, 1, n, st1);
    step();
    rst = 1'b1;
    fdbl_cur = 1'b0;
    exp_q.push_back(vec(0, 0, 0, 0, 0));
    step();
    chk({tag, "_state"}, {4'b0, state}, {4'b0, IDLE});
    rst = 1'b0;
    bus.issue_valid = 1'b0;
    step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_outs", {bus.Stall, bus.fpu_start, bus.fpu_double, bus.fpu_result_valid,
                       bus.mem_hi, bus.fp_double_unsup}, '0);
    chk("reset_state", {4'b0, state}, {4'b0, IDLE});
    step();

    issue("single_add",   1, 0, 0, 0, 0, 0);
    issue("double_add",   1, 1, 0, 0, 0, 0);
    issue("double_load",  0, 1, 1, 1, 0, 0);
    issue("double_store", 0, 1, 1, 0, 1, 0);
    issue("single_load",  0, 0, 1, 1, 0, 0);
    issue("int_op",       0, 0, 0, 0, 0, 0);
    issue("int_op_dbl",   0, 1, 0, 0, 0, 0);
    issue("single_add2",  1, 0, 0, 0, 0, 0);
    issue("valid_in_exec", 1, 1, 0, 0, 0, 1);

    // flush together with issue_valid while idle: no accept
    cur_tag = "flush_vs_valid";
    drive(1, 1, 1, 0, 0, 0, 1);
    exp_q.push_back(vec(0, 0, 0, 0, 0));
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    step();

    flush_op("flush_dbl_add_k2", 1, 1, 0, 0, 0, 2);
    flush_op("flush_sgl_add_k1", 1, 0, 0, 0, 0, 1);
    flush_op("flush_dmem_k1",    0, 1, 1, 1, 0, 1);

    issue("dbl_add_before_rst", 1, 1, 0, 0, 0, 0);
    rst_op("rst_mid_dbl", 1, 1);
    rst_op("rst_mid_sgl", 1, 0);

    // reset beats a simultaneous accept
    cur_tag = "rst_vs_valid";
    drive(1, 1, 0, 0, 0, 0, 0);
    rst = 1'b1;
    fdbl_cur = 1'b0;
    exp_q.push_back(vec(0, 0, 0, 0, 0));
    step();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    step();

    for (int i = 0; i < 20; i++) begin
      issue("rand_op", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 0);
    end

    // ---------------- final report ----------------
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL leftover_expected: got %0d entries expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fp_issue_sequencer.md
FP_ISSUE_SEQUENCER -- requirements
Module: fp_issue_sequencer

Interface
REQ-001 SHALL have one clock and one reset; the reset is synchronous and active-high.
REQ-002 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-003 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-004 SHALL have port issue_valid, input, 1 bit: the decoded instruction is presented this cycle.
REQ-005 SHALL have ports floatop, double, FPLoadStore, MemRead, MemWrite, input, 1 bit each: decode control signals, same meaning as the control unit outputs.
REQ-006 SHALL have port flush, input, 1 bit: kill the in-flight FP op (branch mispredict or jump).
REQ-007 SHALL have port Stall, output, 1 bit: freeze fetch/decode; feeds the control unit Stall input.
REQ-008 SHALL have port fpu_start, output, 1 bit: one-cycle start pulse to the FPU.
REQ-009 SHALL have port fpu_double, output, 1 bit: precision of the op latched at accept.
REQ-010 SHALL have port fpu_result_valid, output, 1 bit: one-cycle pulse; FP result and cc writeback enabled.
REQ-011 SHALL have port mem_hi, output, 1 bit: data memory accesses the upper word (address+4) this cycle.
REQ-012 SHALL have port fp_double_unsup, output, 1 bit: one-cycle pulse when a double op is accepted in a build without double support.

Function
REQ-013 SHALL define accept as issue_valid & (state==IDLE) & ~flush.
REQ-014 SHALL classify the accepted op as follows:
- arith: floatop & ~FPLoadStore
- dmem: FPLoadStore & double & (MemRead|MemWrite)
- all other ops pass with no action and no Stall.
REQ-015 SHALL use states IDLE, EXEC and MEM_HI; all outputs SHALL be registered.
REQ-016 On an arith accept in cycle N, SHALL enter EXEC at N+1 and load the counter with LAT-1, where LAT is FP_DOUBLE_LAT if double, else FP_SINGLE_LAT.
REQ-017 In EXEC, SHALL assert fpu_start in the first cycle only and assert Stall in every cycle, so Stall covers N+1..N+LAT.
REQ-018 In EXEC, SHALL decrement the counter each cycle; in the cycle the counter is 0 it SHALL pulse fpu_result_valid and return to IDLE at the next edge.
REQ-019 On a dmem accept in cycle N, SHALL hold mem_hi=0 at N (pipeline performs beat 0), then enter MEM_HI at N+1 with mem_hi=1 and Stall=1 for exactly one cycle, and return to IDLE at N+2.
REQ-020 While not in IDLE, SHALL ignore issue_valid; upstream holds the instruction under Stall.
REQ-021 On flush in EXEC or MEM_HI, SHALL return to IDLE at the next edge, suppress fpu_result_valid and mem_hi, and clear the counter.
REQ-022 On flush and issue_valid together in IDLE, flush SHALL win and no accept occurs.
REQ-023 The counter SHALL be 3 bits and SHALL never wrap; it SHALL hold at 0 outside EXEC.
REQ-024 SHALL latch fpu_double at accept and hold it until the next accept.

Reset
REQ-025 On rst, SHALL at the next edge set state to IDLE and the counter to 0.
REQ-026 On rst, SHALL at the next edge drive Stall, fpu_start, fpu_double, fpu_result_valid, mem_hi and fp_double_unsup to 0.
REQ-027 rst mid-operation SHALL abort the op with no result pulse; rst SHALL take priority over flush and accept.

Configuration
REQ-028 SHALL support macro FP_SEQ_DOUBLE_EN.
REQ-029 With FP_SEQ_DOUBLE_EN defined, SHALL provide the double behaviour of REQ-016 and REQ-019, and tie fp_double_unsup to 0.
REQ-030 With FP_SEQ_DOUBLE_EN undefined, SHALL:
- ignore double for latency and beat count; all arith ops use FP_SINGLE_LAT and there is no MEM_HI
- hold fpu_double at 0
- pulse fp_double_unsup at N+1 for any accepted op with double=1.

Structure
REQ-031 SHALL place the state enum typedef, FP_SINGLE_LAT=2, FP_DOUBLE_LAT=4 and the counter width in shared package fp_seq_pkg.
REQ-032 SHALL implement the load/decrement/zero-detect counter as sub-module fp_lat_counter.

Verification
REQ-033 Single add accepted at cycle 10 -> fpu_start@11, Stall@11-12, fpu_result_valid@12, IDLE@13.
REQ-034 Double add accepted at cycle 10 (DOUBLE_EN) -> Stall@11-14, fpu_result_valid@14 only.
REQ-035 Double load (opcode 0x35 decode) accepted at cycle 5 -> mem_hi=1 and Stall=1@6 only; single load (0x31) -> no Stall.
REQ-036 Flush at cycle 12 during a double add accepted at 10 -> IDLE@13, no fpu_result_valid, Stall=0@13.
REQ-037 issue_valid during EXEC, and flush plus issue_valid in IDLE -> no accept and no fpu_start.
REQ-038 rst at cycle 12 mid-EXEC -> all outputs 0@13; without DOUBLE_EN a double add -> fp_double_unsup@N+1 and 2-cycle Stall.
